// File: rtl/wb_dec_pkg.sv
// ---------------------------------------------------------------------------
// Module      : wb_dec_pkg
// Description : Shared types, constants and window-select helper for the
//               WISHBONE master decoder.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package wb_dec_pkg;

  // Upper bound on channel count; sizes the match vector and lock index
  localparam int MAX_NCH = 8;
  localparam int IDX_W   = 3;

  // Decoder FSM encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    UNMAP  = 2'd2,
    ABORT  = 2'd3
  } state_e;

  // WISHBONE cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Result of an address decode: any window hit, and the winning channel
  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Pick the lowest-index channel whose window matched
  function automatic dec_t lowest_match(input logic [MAX_NCH-1:0] match);
    dec_t r;
    r.hit = 1'b0;
    r.idx = '0;
    for (int i = MAX_NCH - 1; i >= 0; i--) begin
      if (match[i]) begin
        r.hit = 1'b1;
        r.idx = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_timeout_counter.sv
// ---------------------------------------------------------------------------
// Module      : wb_timeout_counter
// Description : Saturating wait-state counter. Flags expiry in the cycle in
//               which the count would reach TIMEOUT so the caller can abort
//               the strobe in that same cycle.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module wb_timeout_counter #(
  parameter int TW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TW-1:0] c_max  = TW'(TIMEOUT);
  localparam logic [TW-1:0] c_last = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and hold at TIMEOUT
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != c_max)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en & ~clr & (cnt_q >= c_last);

endmodule

`default_nettype wire

// File: rtl/wb_master_decoder.sv
// ---------------------------------------------------------------------------
// Module      : wb_master_decoder
// Description : Routes one upstream WISHBONE master to NCH address-decoded
//               slave channels. The channel is locked for the whole CYC,
//               unmapped addresses get ERR, hung slaves are aborted.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module wb_master_decoder
  import wb_dec_pkg::*;
#(
  parameter int                NCH     = 4,
  parameter int                AW      = 32,
  parameter int                DW      = 32,
  parameter logic [NCH*AW-1:0] CH_BASE = {32'h3000, 32'h2000, 32'h1000, 32'h0000},
  parameter logic [NCH*AW-1:0] CH_MASK = {4{32'hFFFF_F000}},
  parameter int                TIMEOUT = 255,
  parameter int                TW      = 8
) (
  input  logic              WB_CLK,
  input  logic              WB_RST_N,
  // upstream slave side
  input  logic [AW-1:0]     WBS_ADR_I,
  input  logic [DW-1:0]     WBS_DAT_I,
  output logic [DW-1:0]     WBS_DAT_O,
  input  logic [DW/8-1:0]   WBS_SEL_I,
  input  logic              WBS_CYC_I,
  input  logic              WBS_STB_I,
  input  logic              WBS_WE_I,
  input  logic [2:0]        WBS_CTI_I,
  input  logic [1:0]        WBS_BTE_I,
  output logic              WBS_ACK_O,
  output logic              WBS_RTY_O,
  output logic              WBS_ERR_O,
  // downstream channels
  output logic [AW-1:0]     CH_ADR_O,
  output logic [DW-1:0]     CH_DAT_O,
  output logic [DW/8-1:0]   CH_SEL_O,
  output logic              CH_WE_O,
  output logic [2:0]        CH_CTI_O,
  output logic [1:0]        CH_BTE_O,
  input  logic [NCH*DW-1:0] CH_DAT_I,
  output logic [NCH-1:0]    CH_CYC_O,
  output logic [NCH-1:0]    CH_STB_O,
  input  logic [NCH-1:0]    CH_ACK_I,
  input  logic [NCH-1:0]    CH_RTY_I,
  input  logic [NCH-1:0]    CH_ERR_I,
  output logic              TO_EVT
);

  state_e           state_q;
  logic [IDX_W-1:0] sel_q;

  logic [NCH-1:0]   w_match;
  dec_t             w_dec;
  logic [NCH-1:0]   w_sel_oh;
  logic             w_ack;
  logic             w_rty;
  logic             w_err;
  logic [DW-1:0]    w_dat;
  logic             w_active;
  logic             w_term;
  logic             w_cnt_en;
  logic             w_expired;

  // Per-channel window compare on the live upstream address
  for (genvar gi = 0; gi < NCH; gi++) begin : g_match
    assign w_match[gi] = ((WBS_ADR_I & CH_MASK[gi*AW +: AW]) ==
                          (CH_BASE[gi*AW +: AW] & CH_MASK[gi*AW +: AW]));
  end

  assign w_dec = lowest_match(MAX_NCH'(w_match));

  // Select the locked channel's terminations and read data
  always_comb begin
    w_sel_oh = '0;
    w_ack    = 1'b0;
    w_rty    = 1'b0;
    w_err    = 1'b0;
    w_dat    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_q == IDX_W'(i)) begin
        w_sel_oh[i] = 1'b1;
        w_ack       = CH_ACK_I[i];
        w_rty       = CH_RTY_I[i];
        w_err       = CH_ERR_I[i];
        w_dat       = CH_DAT_I[i*DW +: DW];
      end
    end
  end

  assign w_active = (state_q == ACTIVE);
  assign w_term   = w_ack | w_rty | w_err;
  // Only an outstanding, unanswered strobe on the locked channel ages
  assign w_cnt_en = w_active & WBS_STB_I & ~w_term;

  wb_timeout_counter #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (WB_CLK),
    .rst_n   (WB_RST_N),
    .clr     (~w_cnt_en),
    .en      (w_cnt_en),
    .expired (w_expired)
  );

  // Decode on the first strobe, lock until CYC drops, divert on error paths
  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (WBS_CYC_I && WBS_STB_I) begin
            if (w_dec.hit) begin
              state_q <= ACTIVE;
              sel_q   <= w_dec.idx;
            end else begin
              state_q <= UNMAP;
            end
          end
        end
        ACTIVE: begin
          if (!WBS_CYC_I) begin
            state_q <= IDLE;
          end else if (w_expired) begin
            state_q <= ABORT;
          end
        end
        UNMAP: begin
          state_q <= IDLE;
        end
        ABORT: begin
          if (!WBS_CYC_I) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Broadcast bus follows the master directly
  assign CH_ADR_O = WBS_ADR_I;
  assign CH_DAT_O = WBS_DAT_I;
  assign CH_SEL_O = WBS_SEL_I;
  assign CH_WE_O  = WBS_WE_I;
  assign CH_CTI_O = WBS_CTI_I;
  assign CH_BTE_O = WBS_BTE_I;

  // Gated strobes: dropped in the abort cycle so the hung slave is released
  assign CH_CYC_O = (w_active && !w_expired) ? (w_sel_oh & {NCH{WBS_CYC_I}}) : '0;
  assign CH_STB_O = (w_active && !w_expired) ? (w_sel_oh & {NCH{WBS_STB_I}}) : '0;

  assign WBS_ACK_O = w_active & w_ack;
  assign WBS_RTY_O = w_active & w_rty;
  assign WBS_ERR_O = (w_active & w_err) | (state_q == UNMAP) | w_expired;
  assign WBS_DAT_O = w_active ? w_dat : '0;
  assign TO_EVT    = w_expired;

endmodule

`default_nettype wire

// File: tb/tb_wb_master_decoder.sv
// ---------------------------------------------------------------------------
// Module      : tb_wb_master_decoder
// Description : Self-checking bench for wb_master_decoder with a termination
//               scoreboard.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_master_decoder;

  localparam int NCH     = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 255;
  localparam int BOUND   = 400;

  // Per-channel read data as seen by the bench
  localparam logic [31:0] D0 = 32'hA5A5_0000;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'hDEAD_BEEF;
  localparam logic [31:0] D3 = 32'h3333_3333;

  // Termination kinds {TO_EVT, ERR, RTY, ACK}
  localparam logic [3:0] K_ACK = 4'b0001;
  localparam logic [3:0] K_RTY = 4'b0010;
  localparam logic [3:0] K_ERR = 4'b0100;
  localparam logic [3:0] K_TO  = 4'b1100;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0]     WBS_ADR_I = '0;
  logic [DW-1:0]     WBS_DAT_I = '0;
  logic [DW-1:0]     WBS_DAT_O;
  logic [DW/8-1:0]   WBS_SEL_I = '0;
  logic              WBS_CYC_I = 1'b0;
  logic              WBS_STB_I = 1'b0;
  logic              WBS_WE_I  = 1'b0;
  logic [2:0]        WBS_CTI_I = '0;
  logic [1:0]        WBS_BTE_I = '0;
  logic              WBS_ACK_O, WBS_RTY_O, WBS_ERR_O;
  logic [AW-1:0]     CH_ADR_O;
  logic [DW-1:0]     CH_DAT_O;
  logic [DW/8-1:0]   CH_SEL_O;
  logic              CH_WE_O;
  logic [2:0]        CH_CTI_O;
  logic [1:0]        CH_BTE_O;
  logic [NCH*DW-1:0] ch_dat = {D3, D2, D1, D0};
  logic [NCH-1:0]    CH_CYC_O, CH_STB_O, CH_ACK_I, CH_RTY_I, CH_ERR_I;
  logic              TO_EVT;

  // Slave models: answer whenever the master strobes, selected or not
  logic [NCH-1:0] ack_en   = '0;
  logic [NCH-1:0] rty_en   = '0;
  logic           dly_mode = 1'b0;
  int             dly_cnt  = 0;
  logic           w_stb;

  assign w_stb    = WBS_CYC_I & WBS_STB_I;
  assign CH_ACK_I = (ack_en & {NCH{w_stb}}) |
                    {{(NCH-1){1'b0}}, dly_mode & w_stb & (dly_cnt == TIMEOUT)};
  assign CH_RTY_I = rty_en & {NCH{w_stb}};
  assign CH_ERR_I = '0;

  always @(posedge clk) dly_cnt <= w_stb ? dly_cnt + 1 : 0;

  wb_master_decoder u_dut (
    .WB_CLK    (clk),
    .WB_RST_N  (rst_n),
    .WBS_ADR_I (WBS_ADR_I),
    .WBS_DAT_I (WBS_DAT_I),
    .WBS_DAT_O (WBS_DAT_O),
    .WBS_SEL_I (WBS_SEL_I),
    .WBS_CYC_I (WBS_CYC_I),
    .WBS_STB_I (WBS_STB_I),
    .WBS_WE_I  (WBS_WE_I),
    .WBS_CTI_I (WBS_CTI_I),
    .WBS_BTE_I (WBS_BTE_I),
    .WBS_ACK_O (WBS_ACK_O),
    .WBS_RTY_O (WBS_RTY_O),
    .WBS_ERR_O (WBS_ERR_O),
    .CH_ADR_O  (CH_ADR_O),
    .CH_DAT_O  (CH_DAT_O),
    .CH_SEL_O  (CH_SEL_O),
    .CH_WE_O   (CH_WE_O),
    .CH_CTI_O  (CH_CTI_O),
    .CH_BTE_O  (CH_BTE_O),
    .CH_DAT_I  (ch_dat),
    .CH_CYC_O  (CH_CYC_O),
    .CH_STB_O  (CH_STB_O),
    .CH_ACK_I  (CH_ACK_I),
    .CH_RTY_I  (CH_RTY_I),
    .CH_ERR_I  (CH_ERR_I),
    .TO_EVT    (TO_EVT)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  kind;
    logic        chk_dat;
    logic [31:0] dat;
  } exp_t;

  exp_t sb_q[$];

  // Every upstream termination must match the oldest expectation
  always @(negedge clk) begin : mon
    logic [3:0] obs;
    exp_t       e;
    obs = {TO_EVT, WBS_ERR_O, WBS_RTY_O, WBS_ACK_O};
    if (rst_n && (obs != 4'b0000)) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_term", {60'd0, obs}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("term_kind", {60'd0, obs}, {60'd0, e.kind});
        if (e.chk_dat) check_eq("rd_data", {32'd0, WBS_DAT_O}, {32'd0, e.dat});
      end
    end
  end

  // One upstream cycle of 'beats' transfers, then CYC release checks
  task automatic wb_cycle(input logic [31:0] adr, input logic we, input int beats,
                          input logic [2:0] cti, input logic [3:0] exp_cyc,
                          input logic [3:0] kind, input logic [31:0] rdat,
                          input int first_wait, input logic hold);
    int   waits;
    exp_t e;
    @(posedge clk); #1;
    for (int b = 0; b < beats; b++) begin
      WBS_CYC_I = 1'b1;
      WBS_STB_I = 1'b1;
      WBS_WE_I  = we;
      WBS_ADR_I = adr + 32'(4 * b);
      WBS_DAT_I = 32'h5A00_0000 ^ (adr + 32'(4 * b));
      WBS_SEL_I = 4'hF;
      WBS_BTE_I = 2'b00;
      WBS_CTI_I = (cti == 3'b010 && b == beats - 1) ? 3'b111 : cti;
      e.kind    = kind;
      e.chk_dat = ~we;
      e.dat     = rdat;
      sb_q.push_back(e);
      waits = 0;
      do begin
        @(negedge clk);
        waits++;
        if (b == 0 && waits == 1) check_eq("pre_stb", {60'd0, CH_STB_O}, 64'd0);
      end while (!(WBS_ACK_O | WBS_ERR_O | WBS_RTY_O) && waits < BOUND);
      check_eq("beat_wait", 64'(waits), 64'((b == 0) ? first_wait : 1));
      check_eq("ch_cyc", {60'd0, CH_CYC_O}, {60'd0, exp_cyc});
      check_eq("ch_stb", {60'd0, CH_STB_O}, {60'd0, exp_cyc});
      check_eq("bc_adr", {32'd0, CH_ADR_O}, {32'd0, adr + 32'(4 * b)});
      check_eq("bc_ctl", {52'd0, CH_WE_O, CH_SEL_O, CH_CTI_O, CH_BTE_O},
               {52'd0, WBS_WE_I, WBS_SEL_I, WBS_CTI_I, WBS_BTE_I});
      if (we) check_eq("bc_dat", {32'd0, CH_DAT_O}, {32'd0, WBS_DAT_I});
      @(posedge clk); #1;
    end
    if (hold) begin
      WBS_STB_I = 1'b0;
      @(negedge clk);
      check_eq("abort_hold", {60'd0, CH_CYC_O}, 64'd0);
      @(posedge clk); #1;
    end
    WBS_CYC_I = 1'b0;
    WBS_STB_I = 1'b0;
    WBS_CTI_I = 3'b000;
    @(negedge clk);
    check_eq("cyc_drop", {60'd0, CH_CYC_O}, 64'd0);
    @(negedge clk);
    check_eq("idle_dat", {32'd0, WBS_DAT_O}, 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cyc", {56'd0, CH_CYC_O, CH_STB_O}, 64'd0);
    check_eq("rst_term", {60'd0, TO_EVT, WBS_ERR_O, WBS_RTY_O, WBS_ACK_O}, 64'd0);
    check_eq("rst_dat", {32'd0, WBS_DAT_O}, 64'd0);
    rst_n = 1'b1;

    // single read, channel 2
    ack_en = 4'b0100;
    wb_cycle(32'h0000_2004, 1'b0, 1, 3'b000, 4'b0100, K_ACK, D2, 2, 1'b0);

    // incrementing write burst on channel 1
    ack_en = 4'b0010;
    wb_cycle(32'h0000_1000, 1'b1, 4, 3'b010, 4'b0010, K_ACK, 32'h0, 2, 1'b0);

    // read burst running past the window stays on channel 1
    ack_en = 4'b0110;
    wb_cycle(32'h0000_1FF8, 1'b0, 4, 3'b010, 4'b0010, K_ACK, D1, 2, 1'b0);

    // unmapped address
    ack_en = 4'b1111;
    wb_cycle(32'h8000_0000, 1'b0, 1, 3'b000, 4'b0000, K_ERR, 32'h0, 2, 1'b0);

    // retry from channel 0
    ack_en = 4'b0000;
    rty_en = 4'b0001;
    wb_cycle(32'h0000_0010, 1'b0, 1, 3'b000, 4'b0001, K_RTY, D0, 2, 1'b0);
    rty_en = 4'b0000;

    // silent channel 3 times out on the 256th strobe cycle
    ack_en = 4'b0111;
    wb_cycle(32'h0000_3000, 1'b1, 1, 3'b000, 4'b0000, K_TO, 32'h0, 256, 1'b1);

    // channel 0 answers exactly when the count would expire
    ack_en   = 4'b1110;
    dly_mode = 1'b1;
    wb_cycle(32'h0000_0040, 1'b0, 1, 3'b000, 4'b0001, K_ACK, D0, 256, 1'b0);
    dly_mode = 1'b0;

    // reset in the middle of a stalled burst on channel 1
    ack_en = 4'b0000;
    @(posedge clk); #1;
    WBS_CYC_I = 1'b1;
    WBS_STB_I = 1'b1;
    WBS_WE_I  = 1'b1;
    WBS_ADR_I = 32'h0000_1000;
    WBS_CTI_I = 3'b010;
    repeat (3) @(negedge clk);
    check_eq("rst_pre", {60'd0, CH_CYC_O}, {60'd0, 4'b0010});
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async", {60'd0, CH_CYC_O}, 64'd0);
    check_eq("rst_noterm", {61'd0, WBS_ERR_O, WBS_RTY_O, WBS_ACK_O}, 64'd0);
    @(posedge clk); #1;
    WBS_CYC_I = 1'b0;
    WBS_STB_I = 1'b0;
    WBS_CTI_I = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;

    // fresh decode after reset, channel 3
    ack_en = 4'b1000;
    wb_cycle(32'h0000_3000, 1'b0, 1, 3'b000, 4'b1000, K_ACK, D3, 2, 1'b0);

    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
